datmem_port_arbiter: RTL and testbench
======================================

// Module: datmem_port_arbiter
// PURPOSE
//  Shares the 32-byte, byte-wide data memory between two word-wide requesters:
//  port A (processor load/store) and port B (loader/debug).
//  Grants one requester at a time and sequences each 32-bit access as four byte
//  beats, big-endian: byte at addr holds bits 31:24. Returns one ack per word.
//  Sits between the requesters and the datmem byte array.
// PARAMETERS
//  ADDR_W  5  byte-address width; memory depth = 2**ADDR_W bytes
// PORTS
//  clk        in   1       clock; all state changes on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  a_req      in   1       port A request; hold stable until a_ack
//  a_we       in   1       port A: 1 = write word, 0 = read word
//  a_addr     in   ADDR_W  port A byte base address
//  a_wdata    in   32      port A write word
//  a_ack      out  1       port A done, 1-cycle pulse
//  a_rdata    out  32      port A read word, valid while a_ack=1, held after
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata: same as port A, for port B
//  mem_addr   out  ADDR_W  byte address to datmem
//  mem_we     out  1       byte write strobe (written on posedge)
//  mem_wdata  out  8       byte write data
//  mem_rdata  in   8       byte read data, combinational from mem_addr
//  busy       out  1       1 in XFER or RESP
//  owner      out  1       0 = A, 1 = B; valid while busy
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, beat=0, last=B. All outputs are 0:
//   acks, rdata, mem_*, busy, owner.
//  FSM states: IDLE -> XFER -> RESP -> IDLE.
//  IDLE: on posedge, if any req=1, latch owner, we, addr and wdata, set beat=0,
//   and go to XFER.
//   Only A: A wins. Only B: B wins.
//   Both: round-robin; grant the port != last.
//  XFER: mem_addr = (addr + beat) mod 2**ADDR_W. Wrap: 31 is followed by 0.
//   Write: mem_we=1, mem_wdata = wdata byte [31-8*beat -: 8].
//   Read: mem_we=0; on posedge, mem_rdata is stored into rdata byte (3-beat).
//   Beat increments each posedge. Leave XFER on the posedge where beat=3.
//  RESP: the owner's ack=1 for exactly one cycle; rdata holds the assembled word.
//   last <= owner; go to IDLE on the next posedge.
//   Requests are not sampled in RESP.
//  Latency: grant edge G, beats at cycles G+1..G+4, ack at cycle G+5.
//   A back-to-back request is re-granted no earlier than 2 cycles after ack.
//  Handshake: the requester drops req on the posedge that samples ack.
//   Dropping req or changing inputs mid-transfer has no effect, because they
//   were latched at grant; the transfer completes.
//  Non-owner req is held pending and never lost; the other port's rdata and
//   ack are unchanged.
//  Reset mid-transfer aborts it: mem_we falls asynchronously, bytes already
//   written remain, no ack is issued.
//  No alignment check: any base address is legal; wrap as above.
// TESTING
//  1 A write 0xDEADBEEF @4 -> mem[4..7]=DE,AD,BE,EF; a_ack exactly 5 cycles
//    after grant edge; b_ack=0 throughout.
//  2 A read @4 after test 1 -> a_rdata=0xDEADBEEF with a_ack; mem_we=0 in all beats.
//  3 A and B req in same cycle from reset -> A served first, then B;
//    with both held continuously, order is A,B,A,B.
//  4 B write 0x11223344 @30 -> mem[30]=11, mem[31]=22, mem[0]=33, mem[1]=44.
//  5 rst_n=0 during beat 2 of a write 0xAABBCCDD @8 -> mem[8]=AA, mem[9]=BB;
//    mem[10], mem[11] unchanged; no ack; busy=0 immediately.
//  6 A drops a_req and changes a_addr during beat 1 -> transfer completes at
//    the original address and a_ack still pulses.

Source files
------------

// File: rtl/datmem_port_arbiter.sv
// Two-port word arbiter for the byte-wide data memory.
// Grants port A or B round-robin and splits each word into four big-endian byte beats.
module datmem_port_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_beat;
  logic                r_last;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [23:0]         r_buf;
  logic [31:0]         r_a_rdata;
  logic [31:0]         r_b_rdata;
  logic                w_grant;
  logic                w_grant_b;
  logic [ADDR_W-1:0]   w_byte_addr;
  logic [7:0]          w_wbyte;

  // When both ports ask at once, the port that was not served last wins.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req || b_req) begin
          w_grant      = 1'b1;
          w_grant_b    = b_req && (!a_req || !r_last);
          w_next_state = S_XFER;
        end
      end
      S_XFER: begin
        if (r_beat == 2'd3) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_byte_addr = r_addr + ADDR_W'(r_beat);

  always_comb begin
    w_wbyte = 8'h00;
    case (r_beat)
      2'd0:    w_wbyte = r_wdata[31:24];
      2'd1:    w_wbyte = r_wdata[23:16];
      2'd2:    w_wbyte = r_wdata[15:8];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // Memory-side signals are forced to zero outside XFER so reset drops them at once.
  assign mem_addr  = (r_state == S_XFER) ? w_byte_addr : '0;
  assign mem_we    = (r_state == S_XFER) && r_we;
  assign mem_wdata = ((r_state == S_XFER) && r_we) ? w_wbyte : 8'h00;
  assign busy      = (r_state != S_IDLE);
  assign owner     = busy && r_owner;
  assign a_ack     = (r_state == S_RESP) && !r_owner;
  assign b_ack     = (r_state == S_RESP) && r_owner;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request fields are captured at grant so later requester changes cannot disturb a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat    <= 2'd0;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_buf     <= 24'h0;
      r_a_rdata <= 32'h0;
      r_b_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_grant_b;
            r_we    <= w_grant_b ? b_we    : a_we;
            r_addr  <= w_grant_b ? b_addr  : a_addr;
            r_wdata <= w_grant_b ? b_wdata : a_wdata;
            r_beat  <= 2'd0;
          end
        end
        S_XFER: begin
          r_beat <= r_beat + 2'd1;
          if (!r_we) begin
            case (r_beat)
              2'd0: r_buf[23:16] <= mem_rdata;
              2'd1: r_buf[15:8]  <= mem_rdata;
              2'd2: r_buf[7:0]   <= mem_rdata;
              default: begin
                if (r_owner) begin
                  r_b_rdata <= {r_buf, mem_rdata};
                end else begin
                  r_a_rdata <= {r_buf, mem_rdata};
                end
              end
            endcase
          end
        end
        S_RESP: begin
          r_last <= r_owner;
        end
        default: begin
          r_beat <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datmem_port_arbiter.sv
// Directed bench for datmem_port_arbiter with a behavioural 32-byte memory.
// Expected values are hand-computed from the memory's initial contents (mem[i] = i).
module tb_datmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, mem_we, busy, owner;
  logic [31:0] a_rdata, b_rdata;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [32];
  logic        memLoaded = 1'b0;
  int          errCount = 0;
  int          checkCount = 0;

  datmem_port_arbiter #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Byte memory: combinational read, posedge write, loaded with mem[i] = i on the first edge.
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
      memLoaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic req);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // One full word transfer on one port; disturb drops req and moves the address during beat 1.
  task automatic runWord(input string tag, input logic port, input logic we, input logic [4:0] addr,
                         input logic [31:0] wdata, input logic [31:0] expRdata, input logic disturb);
    logic       granted = 1'b0;
    logic       otherAck = 1'b0;
    int         ackAt = 0;
    logic [4:0] expAddr;
    logic [7:0] expByte;
    applyStimulus(port, we, addr, wdata, 1'b1);
    for (int i = 0; i < 10 && !granted; i++) begin
      @(posedge clk); #1;
      if (busy && owner == port) granted = 1'b1;
    end
    checkOutput({tag, "_grant"}, 32'(granted), 32'd1);
    for (int n = 1; n <= 10 && ackAt == 0; n++) begin
      @(negedge clk);
      if (disturb && n == 2) applyStimulus(port, we, addr + 5'd8, 32'h0, 1'b0);
      if ((port ? a_ack : b_ack) == 1'b1) otherAck = 1'b1;
      if ((port ? b_ack : a_ack) == 1'b1) ackAt = n;
      else if (n <= 4) begin
        expAddr = addr + 5'(n - 1);
        expByte = we ? 8'(wdata >> (24 - 8 * (n - 1))) : 8'h00;
        checkOutput($sformatf("%s_addr%0d", tag, n - 1), 32'(mem_addr), 32'(expAddr));
        checkOutput($sformatf("%s_we%0d", tag, n - 1), 32'(mem_we), 32'(we));
        checkOutput($sformatf("%s_wdata%0d", tag, n - 1), 32'(mem_wdata), 32'(expByte));
      end
    end
    checkOutput({tag, "_ackLatency"}, 32'(ackAt), 32'd5);
    checkOutput({tag, "_otherAck"}, 32'(otherAck), 32'd0);
    if (!we) checkOutput({tag, "_rdata"}, port ? b_rdata : a_rdata, expRdata);
    @(posedge clk); #1;
    applyStimulus(port, we, addr, wdata, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_ackPulse"}, 32'(port ? b_ack : a_ack), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       found;
    logic       who;
    logic       sawAck;
    logic       gotGrant;
    repeat (2) @(negedge clk);
    checkOutput("rst_a_ack", 32'(a_ack), 32'd0);
    checkOutput("rst_b_ack", 32'(b_ack), 32'd0);
    checkOutput("rst_a_rdata", a_rdata, 32'h0);
    checkOutput("rst_b_rdata", b_rdata, 32'h0);
    checkOutput("rst_mem", {19'h0, mem_addr, mem_wdata}, 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy_owner", {30'h0, busy, owner}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] test 1: A write 0xDEADBEEF @4");
    runWord("t1", 1'b0, 1'b1, 5'd4, 32'hDEADBEEF, 32'h0, 1'b0);
    checkOutput("t1_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);

    $display("[TB] test 2: A read @4");
    runWord("t2", 1'b0, 1'b0, 5'd4, 32'h0, 32'hDEADBEEF, 1'b0);

    // Both ports held continuously from reset: the order must alternate starting with A.
    $display("[TB] test 3: simultaneous requests");
    doReset();
    applyStimulus(1'b0, 1'b0, 5'd4, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd30, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      who = 1'b0;
      for (int n = 0; n < 12 && !found; n++) begin
        @(negedge clk);
        if (a_ack || b_ack) begin
          found = 1'b1;
          who = b_ack;
        end
      end
      checkOutput($sformatf("t3_order%0d", k), found ? 32'(who) : 32'd2, 32'(k % 2));
      if (found && !who) checkOutput($sformatf("t3_a_rdata%0d", k), a_rdata, 32'hDEADBEEF);
      if (found && who) checkOutput($sformatf("t3_b_rdata%0d", k), b_rdata, 32'h1E1F0001);
    end
    applyStimulus(1'b0, 1'b0, 5'd4, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd30, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t3_idle", 32'(busy), 32'd0);

    $display("[TB] test 4: B write 0x11223344 @30 with wrap");
    runWord("t4", 1'b1, 1'b1, 5'd30, 32'h11223344, 32'h0, 1'b0);
    checkOutput("t4_mem", {mem[30], mem[31], mem[0], mem[1]}, 32'h11223344);
    runWord("t4r", 1'b0, 1'b0, 5'd30, 32'h0, 32'h11223344, 1'b0);
    checkOutput("t4r_b_rdata_kept", b_rdata, 32'h1E1F0001);

    // Reset lands during beat 2; only the first two bytes may reach memory.
    $display("[TB] test 5: reset mid-write");
    applyStimulus(1'b0, 1'b1, 5'd8, 32'hAABBCCDD, 1'b1);
    gotGrant = 1'b0;
    for (int i = 0; i < 10 && !gotGrant; i++) begin
      @(posedge clk); #1;
      if (busy) gotGrant = 1'b1;
    end
    checkOutput("t5_grant", 32'(gotGrant), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("t5_beat2_addr", 32'(mem_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_we_async", 32'(mem_we), 32'd0);
    checkOutput("t5_busy_async", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd8, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sawAck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ack || b_ack || busy) sawAck = 1'b1;
    end
    checkOutput("t5_no_ack", 32'(sawAck), 32'd0);
    checkOutput("t5_mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB0A0B);

    $display("[TB] test 6: A changes inputs mid-transfer");
    runWord("t6", 1'b0, 1'b1, 5'd12, 32'h01020304, 32'h0, 1'b1);
    checkOutput("t6_mem", {mem[12], mem[13], mem[14], mem[15]}, 32'h01020304);
    checkOutput("t6_mem20", 32'(mem[20]), 32'h14);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
